// File: rtl/fir_pkg.sv
// Shared types, constants and the round/limit helper for the cascadable FIR segment.
// FIR_BLOCK_SAT_EN selects clamping of the rounded result; otherwise it wraps.
package fir_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_BITS = 15;
    localparam int unsigned MAX_TAPS  = 8;
    localparam int unsigned ACC_GUARD = $clog2(MAX_TAPS + 1);
    localparam int unsigned ACC_MAX_W = 64;

    typedef logic signed [DATA_W-1:0] sample_t;

    // c0 sits in the least-significant DATA_W bits
    localparam logic [4*DATA_W-1:0] DEFAULT_COEFS =
        {16'sh1000, 16'sh2000, 16'sh2000, 16'sh1000};

    // Round half-up, drop frac bits, then limit to width bits (sign-extended result)
    function automatic logic signed [ACC_MAX_W-1:0] round_limit(
        input logic signed [ACC_MAX_W-1:0] acc,
        input int unsigned                 width,
        input int unsigned                 frac
    );
        logic signed [ACC_MAX_W-1:0] r;
        logic signed [ACC_MAX_W-1:0] half;
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        half = 64'sd1 <<< (frac - 1);
        r    = acc + half;
        r    = r >>> frac;
        hi   = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (width - 1));
`ifdef FIR_BLOCK_SAT_EN
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
`else
        if ((r > hi) || (r < lo)) begin
            r = (r <<< (ACC_MAX_W - width)) >>> (ACC_MAX_W - width);
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/fir_filter_block_fir_tap_mac.sv
// Signed WIDTH x WIDTH multiplier for one FIR tap; combinational full-precision product.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]   x,
    input  logic signed [WIDTH-1:0]   c,
    output logic signed [2*WIDTH-1:0] p_c
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    assign p_c = PROD_W'(x) * PROD_W'(c);

endmodule

// File: rtl/fir_filter_block.sv
// Cascadable FIR segment: forwards the sample stream and adds its partial sum to y_in.
// Build option FIR_BLOCK_SAT_EN clamps the result instead of wrapping it.
module fir_filter_block #(
    parameter int unsigned             TAPS      = 4,
    parameter int unsigned             WIDTH     = fir_pkg::DATA_W,
    parameter int unsigned             FRAC_BITS = fir_pkg::FRAC_BITS,
    parameter logic [TAPS*WIDTH-1:0]   COEFS     = fir_pkg::DEFAULT_COEFS
) (
    input  logic                    clk,
    input  logic                    rst_p,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out
);
    import fir_pkg::*;

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(TAPS + 1);

    logic signed [WIDTH-1:0]  r    [1:TAPS+1];
    logic signed [WIDTH-1:0]  tap  [TAPS];
    logic signed [PROD_W-1:0] prod [TAPS];
    logic signed [ACC_W-1:0]  acc_c;

    // Tap 0 is the live input so y_out reflects x_in on the same edge
    assign tap[0] = x_in;

    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        assign tap[k] = r[k];
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_mac
        fir_tap_mac #(
            .WIDTH (WIDTH)
        ) u_mac (
            .x   (tap[k]),
            .c   (COEFS[k*WIDTH +: WIDTH]),
            .p_c (prod[k])
        );
    end

    // Full-precision sum: upstream partial scaled by 1.0 plus all tap products
    always_comb begin
        acc_c = ACC_W'(y_in) <<< FRAC_BITS;
        for (int k = 0; k < TAPS; k++) begin
            acc_c = acc_c + ACC_W'(prod[k]);
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            for (int i = 1; i <= TAPS + 1; i++) begin
                r[i] <= '0;
            end
            y_out <= '0;
        end else begin
            r[1] <= x_in;
            for (int i = 2; i <= TAPS + 1; i++) begin
                r[i] <= r[i-1];
            end
            y_out <= WIDTH'(round_limit(ACC_MAX_W'(acc_c), WIDTH, FRAC_BITS));
        end
    end

    assign x_out = r[TAPS+1];

endmodule

// File: tb/tb_fir_filter_block.sv
// Directed bench for fir_filter_block: reset, impulse, x_out delay, pass-through,
// rounding, limiting and a two-segment cascade.
module tb_fir_filter_block;

    logic               clk   = 1'b0;
    logic               rst_p = 1'b1;
    logic signed [15:0] x_in  = '0;
    logic signed [15:0] y_in  = '0;
    logic signed [15:0] zero16 = '0;
    logic signed [15:0] x_out, y_out;
    logic signed [15:0] c1_x, c1_y, c2_x, c2_y;

    int n_cmp  = 0;
    int n_fail = 0;

    int y_imp  [10] = '{2048, 4096, 4096, 2048, 0, 0, 0, 0, 0, 0};
    int xo_imp [10] = '{0, 0, 0, 0, 16384, 0, 0, 0, 0, 0};
    int casc   [10] = '{0, 2048, 4096, 4096, 2048, 0, 0, 0, 8192, 0};
    int ramp   [6]  = '{4096, 12288, 20479, 24575, 24575, 24575};

    always #5 clk = ~clk;

    fir_filter_block u_dut (
        .clk   (clk),
        .rst_p (rst_p),
        .x_in  (x_in),
        .y_in  (y_in),
        .x_out (x_out),
        .y_out (y_out)
    );

    fir_filter_block u_c1 (
        .clk   (clk),
        .rst_p (rst_p),
        .x_in  (x_in),
        .y_in  (zero16),
        .x_out (c1_x),
        .y_out (c1_y)
    );

    fir_filter_block #(
        .COEFS ({16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000})
    ) u_c2 (
        .clk   (clk),
        .rst_p (rst_p),
        .x_in  (c1_x),
        .y_in  (c1_y),
        .x_out (c2_x),
        .y_out (c2_y)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_sat;

        // reset state
        repeat (2) step();
        check("reset_x_out", int'(x_out), 0);
        check("reset_y_out", int'(y_out), 0);
        rst_p = 1'b0;
        repeat (3) step();
        check("idle_x_out", int'(x_out), 0);
        check("idle_y_out", int'(y_out), 0);

        // impulse through single block and through the cascade
        for (int j = 0; j < 10; j++) begin
            x_in = (j == 0) ? 16'sd16384 : 16'sd0;
            step();
            check($sformatf("imp_y_%0d", j), int'(y_out), y_imp[j]);
            check($sformatf("imp_xo_%0d", j), int'(x_out), xo_imp[j]);
            check($sformatf("casc_y_%0d", j), int'(c2_y), casc[j]);
        end

        // x_out delay of a small sample
        for (int j = 0; j < 6; j++) begin
            x_in = (j == 0) ? 16'sd5 : 16'sd0;
            step();
            check($sformatf("xdel_%0d", j), int'(x_out), (j == 4) ? 5 : 0);
        end

        // y_in pass-through
        y_in = 16'sd1000;
        step();
        check("pass_1000", int'(y_out), 1000);
        y_in = 16'sd0;
        step();
        check("pass_0", int'(y_out), 0);

        // rounding ramp to steady state with full-scale input
        x_in = 16'sd32767;
        for (int j = 0; j < 6; j++) begin
            step();
            check($sformatf("ramp_%0d", j), int'(y_out), ramp[j]);
        end

        // overflow of the rounded result
`ifdef FIR_BLOCK_SAT_EN
        exp_sat = 32767;
`else
        exp_sat = -8194;
`endif
        y_in = 16'sd32767;
        step();
        check("limit_a", int'(y_out), exp_sat);
        step();
        check("limit_b", int'(y_out), exp_sat);
        check("pre_rst_x_out", int'(x_out), 32767);

        // asynchronous reset mid-cycle
        #3;
        rst_p = 1'b1;
        #1;
        check("async_rst_x_out", int'(x_out), 0);
        check("async_rst_y_out", int'(y_out), 0);
        x_in = 16'sd0;
        y_in = 16'sd0;
        step();
        rst_p = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("post_rst_y_%0d", j), int'(y_out), 0);
            check($sformatf("post_rst_x_%0d", j), int'(x_out), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
